// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// ----------------------------------------------------------------------------
// Shares the single memory port of the multicycle core between two masters:
// the core's fetch/load/store path (port C) and a DMA/debug master (port D).
// One transaction is accepted at a time. Its fields are latched and driven to
// memory until mem_ready, then the winner gets a one-cycle ack with the read
// data. A watchdog aborts hung accesses and returns an error ack instead.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  - when defined, simultaneous requests in IDLE are
//                         granted to the master that did not win last time.
//                         When undefined, C always beats D.
//
// Parameters:
//   ADDR_W          address width of all ports
//   DATA_W          data width (multiple of 8)
//   TIMEOUT_CYCLES  mem_req-high cycles without mem_ready before an abort;
//                   0 disables the watchdog
//
// Ports:
//   clk, reset                       rising-edge clock, sync active-high reset
//   c_req/c_we/c_addr/c_wdata/c_wstrb   core request and its fields
//   c_ack/c_err/c_rdata                 core completion pulse, error, data
//   d_*                                 same set for the DMA/debug master
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   memory request side
//   mem_rdata/mem_ready                 memory response side
//   busy                                high whenever the FSM is not IDLE
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    input  logic [DATA_W/8-1:0] c_wstrb,
    output logic                c_ack,
    output logic                c_err,
    output logic [DATA_W-1:0]   c_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic                d_err,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,

    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    // The counter only ever has to reach TIMEOUT_CYCLES-1, so it is sized for
    // that value. With the watchdog disabled it simply wraps harmlessly.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_C = 2'd1,
        BUSY_D = 2'd2,
        ACK    = 2'd3
    } arbState_e;

    arbState_e           state_q,      state_d;
    logic                memReq_q,     memReq_d;
    logic                memWe_q,      memWe_d;
    logic [ADDR_W-1:0]   memAddr_q,    memAddr_d;
    logic [DATA_W-1:0]   memWdata_q,   memWdata_d;
    logic [STRB_W-1:0]   memWstrb_q,   memWstrb_d;
    logic                cAck_q,       cAck_d;
    logic                cErr_q,       cErr_d;
    logic [DATA_W-1:0]   cRdata_q,     cRdata_d;
    logic                dAck_q,       dAck_d;
    logic                dErr_q,       dErr_d;
    logic [DATA_W-1:0]   dRdata_q,     dRdata_d;
    logic                busy_q,       busy_d;
    logic [CNT_W-1:0]    timeoutCnt_q, timeoutCnt_d;
    logic                lastGrantD_q, lastGrantD_d;

    logic                preferC;
    logic                grantD;
    logic                accessDone;
    logic                accessErr;
    logic [DATA_W-1:0]   accessRdata;

    // Arbitration decision for an IDLE cycle. preferC says whether C should
    // win when both masters are requesting. In the round-robin build that is
    // true exactly when D won last time; in the fixed-priority build C always
    // wins, although the last-grant pointer keeps being tracked.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        preferC = lastGrantD_q;
`else
        preferC = lastGrantD_q | 1'b1;
`endif
        grantD = d_req && !(c_req && preferC);
    end

    // Completion of the access in flight. mem_ready takes precedence over the
    // watchdog when both happen in the same cycle, so a late-but-valid
    // response is never thrown away. Writes and aborted accesses return zero
    // data so the requester never sees stale bus contents.
    always_comb begin
        accessDone  = 1'b0;
        accessErr   = 1'b0;
        accessRdata = '0;
        if (mem_ready && memReq_q) begin
            accessDone  = 1'b1;
            accessRdata = memWe_q ? '0 : mem_rdata;
        end else if (TIMEOUT_EN && (timeoutCnt_q == CNT_LAST)) begin
            accessDone = 1'b1;
            accessErr  = 1'b1;
        end
    end

    // Next-state and next-output logic. Everything that leaves the block is
    // registered, so this process computes the _d value of every output
    // register. Acks default low so they can only ever be single-cycle
    // pulses; everything else holds by default.
    always_comb begin
        state_d      = state_q;
        memReq_d     = memReq_q;
        memWe_d      = memWe_q;
        memAddr_d    = memAddr_q;
        memWdata_d   = memWdata_q;
        memWstrb_d   = memWstrb_q;
        cAck_d       = 1'b0;
        cErr_d       = 1'b0;
        cRdata_d     = cRdata_q;
        dAck_d       = 1'b0;
        dErr_d       = 1'b0;
        dRdata_d     = dRdata_q;
        timeoutCnt_d = timeoutCnt_q;
        lastGrantD_d = lastGrantD_q;

        case (state_q)
            IDLE: begin
                if (c_req || d_req) begin
                    memReq_d     = 1'b1;
                    memWe_d      = grantD ? d_we    : c_we;
                    memAddr_d    = grantD ? d_addr  : c_addr;
                    memWdata_d   = grantD ? d_wdata : c_wdata;
                    memWstrb_d   = grantD ? d_wstrb : c_wstrb;
                    timeoutCnt_d = '0;
                    lastGrantD_d = grantD;
                    state_d      = grantD ? BUSY_D : BUSY_C;
                end
            end

            BUSY_C, BUSY_D: begin
                timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
                if (accessDone) begin
                    memReq_d     = 1'b0;
                    timeoutCnt_d = '0;
                    state_d      = ACK;
                    if (state_q == BUSY_C) begin
                        cAck_d   = 1'b1;
                        cErr_d   = accessErr;
                        cRdata_d = accessRdata;
                    end else begin
                        dAck_d   = 1'b1;
                        dErr_d   = accessErr;
                        dRdata_d = accessRdata;
                    end
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d  = IDLE;
                memReq_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset is synchronous: a transaction in
    // flight is dropped on the reset edge without any ack, and the grant
    // pointer goes back to D so the first contended grant afterwards is C.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            memWstrb_q   <= '0;
            cAck_q       <= 1'b0;
            cErr_q       <= 1'b0;
            cRdata_q     <= '0;
            dAck_q       <= 1'b0;
            dErr_q       <= 1'b0;
            dRdata_q     <= '0;
            busy_q       <= 1'b0;
            timeoutCnt_q <= '0;
            lastGrantD_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            memReq_q     <= memReq_d;
            memWe_q      <= memWe_d;
            memAddr_q    <= memAddr_d;
            memWdata_q   <= memWdata_d;
            memWstrb_q   <= memWstrb_d;
            cAck_q       <= cAck_d;
            cErr_q       <= cErr_d;
            cRdata_q     <= cRdata_d;
            dAck_q       <= dAck_d;
            dErr_q       <= dErr_d;
            dRdata_q     <= dRdata_d;
            busy_q       <= busy_d;
            timeoutCnt_q <= timeoutCnt_d;
            lastGrantD_q <= lastGrantD_d;
        end
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign mem_wstrb = memWstrb_q;
    assign c_ack     = cAck_q;
    assign c_err     = cErr_q;
    assign c_rdata   = cRdata_q;
    assign d_ack     = dAck_q;
    assign d_err     = dErr_q;
    assign d_rdata   = dRdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for mem_port_arbiter, built with an 8-cycle watchdog.
// Directed steps cover reset, a core read, a DMA write with the core queued
// behind it, watchdog expiry and the ready-on-last-cycle boundary, reset in
// the middle of a DMA access and contended grant order. A randomized phase
// then runs transactions with random masters, fields and memory latency.
//
// Expected behaviour comes from a transaction-level model: who wins (from the
// priority / last-grantee rule), how many cycles mem_req stays high (latency
// or watchdog limit), and what the ack carries (data, zero, or error).
// Honours ARB_ROUND_ROBIN_EN so it can check either build.
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STRB_W     = DATA_W / 8;
    localparam int TB_TIMEOUT = 8;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                c_req;
    logic                c_we;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata;
    logic [STRB_W-1:0]   c_wstrb;
    logic                c_ack;
    logic                c_err;
    logic [DATA_W-1:0]   c_rdata;
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [STRB_W-1:0]   d_wstrb;
    logic                d_ack;
    logic                d_err;
    logic [DATA_W-1:0]   d_rdata;
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [STRB_W-1:0]   mem_wstrb;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ready;
    logic                busy;

    int checks = 0;
    int errors = 0;

    // Model state: which master won the most recent grant.
    bit lastWasD    = 1'b1;
    bit lastWinnerD = 1'b0;

    mem_port_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_wstrb   (c_wstrb),
        .c_ack     (c_ack),
        .c_err     (c_err),
        .c_rdata   (c_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic raiseC();
        c_req   = 1'b1;
        c_we    = 1'($urandom_range(0, 1));
        c_addr  = $urandom;
        c_wdata = $urandom;
        c_wstrb = STRB_W'($urandom_range(0, 15));
    endtask

    task automatic raiseD();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_wstrb = STRB_W'($urandom_range(0, 15));
    endtask

    // Run one transaction starting from an IDLE cycle with the requests
    // already driven. lat = number of BUSY cycles before mem_ready is given
    // (a value at or beyond the watchdog limit means memory never answers).
    // lateOther raises the losing master's request during the first BUSY
    // cycle so it has to wait its turn.
    task automatic applyStimulus(input int lat, input logic [DATA_W-1:0] rd,
                                 input bit lateOther);
        bit                winD;
        bit                expErr;
        logic              expWe;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expWdata;
        logic [STRB_W-1:0] expStrb;
        logic [DATA_W-1:0] expRdata;
        int                expHigh;
        int                highCnt;
        int                k;
        bit                done;

        if (c_req && d_req) winD = RR_MODE ? !lastWasD : 1'b0;
        else                winD = d_req;
        lastWasD    = winD;
        lastWinnerD = winD;

        expWe    = winD ? d_we    : c_we;
        expAddr  = winD ? d_addr  : c_addr;
        expWdata = winD ? d_wdata : c_wdata;
        expStrb  = winD ? d_wstrb : c_wstrb;
        expErr   = (lat >= TB_TIMEOUT);
        expHigh  = expErr ? TB_TIMEOUT : lat + 1;
        expRdata = (expErr || expWe) ? '0 : rd;

        mem_ready = 1'b0;
        tick();
        checkOutput("grant.mem_req",   64'(mem_req),   64'(1'b1));
        checkOutput("grant.mem_we",    64'(mem_we),    64'(expWe));
        checkOutput("grant.mem_addr",  64'(mem_addr),  64'(expAddr));
        checkOutput("grant.mem_wdata", 64'(mem_wdata), 64'(expWdata));
        checkOutput("grant.mem_wstrb", 64'(mem_wstrb), 64'(expStrb));
        checkOutput("grant.busy",      64'(busy),      64'(1'b1));

        k       = 0;
        highCnt = 0;
        done    = 1'b0;
        while (!done) begin
            if (mem_req === 1'b1) highCnt++;
            if (lateOther && k == 0) begin
                if (winD && !c_req)       raiseC();
                else if (!winD && !d_req) raiseD();
            end
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rd : $urandom;
            tick();
            if (k == lat || k == TB_TIMEOUT - 1) begin
                done = 1'b1;
            end else begin
                checkOutput("hold.mem_req",  64'(mem_req),  64'(1'b1));
                checkOutput("hold.mem_addr", 64'(mem_addr), 64'(expAddr));
                checkOutput("hold.acks",     64'({c_ack, d_ack}), 64'(2'b00));
                k++;
            end
        end
        mem_ready = 1'b0;

        checkOutput("ack.mem_req_cycles", 64'(highCnt), 64'(expHigh));
        checkOutput("ack.winner_ack", 64'(winD ? d_ack : c_ack), 64'(1'b1));
        checkOutput("ack.loser_ack",  64'(winD ? c_ack : d_ack), 64'(1'b0));
        checkOutput("ack.err",        64'(winD ? d_err : c_err), 64'(expErr));
        checkOutput("ack.rdata",      64'(winD ? d_rdata : c_rdata), 64'(expRdata));
        checkOutput("ack.mem_req",    64'(mem_req), 64'(1'b0));
        checkOutput("ack.busy",       64'(busy),    64'(1'b1));

        if (winD) d_req = 1'b0;
        else      c_req = 1'b0;

        tick();
        checkOutput("idle.acks",    64'({c_ack, d_ack}), 64'(2'b00));
        checkOutput("idle.busy",    64'(busy),    64'(1'b0));
        checkOutput("idle.mem_req", 64'(mem_req), 64'(1'b0));
    endtask

    initial begin
        reset     = 1'b1;
        c_req     = 1'b0;
        c_we      = 1'b0;
        c_addr    = '0;
        c_wdata   = '0;
        c_wstrb   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_wstrb   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("reset.mem_req",  64'(mem_req),  64'(1'b0));
        checkOutput("reset.mem_we",   64'(mem_we),   64'(1'b0));
        checkOutput("reset.mem_addr", 64'(mem_addr), 64'(0));
        checkOutput("reset.acks",     64'({c_ack, d_ack, c_err, d_err}), 64'(0));
        checkOutput("reset.rdata",    64'({c_rdata, d_rdata}), 64'(0));
        checkOutput("reset.busy",     64'(busy),     64'(1'b0));
        reset = 1'b0;
        tick();

        // Core read answered on the second BUSY cycle
        c_req   = 1'b1;
        c_we    = 1'b0;
        c_addr  = 32'h0000_0100;
        c_wdata = 32'h5555_AAAA;
        c_wstrb = 4'hF;
        applyStimulus(1, 32'hDEAD_BEEF, 1'b0);

        // DMA write with the core arriving one cycle later; core goes next
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = 32'h0000_1234;
        d_wstrb = 4'b0011;
        applyStimulus(0, 32'hFFFF_FFFF, 1'b1);
        checkOutput("dma_first.winner", 64'(lastWinnerD), 64'(1'b1));
        applyStimulus(0, $urandom, 1'b0);
        checkOutput("core_after.winner", 64'(lastWinnerD), 64'(1'b0));

        // Watchdog expiry, then mem_ready on the very last allowed cycle
        c_req   = 1'b1;
        c_we    = 1'b0;
        c_addr  = 32'h0000_0300;
        c_wdata = 32'h0;
        c_wstrb = 4'hF;
        applyStimulus(20, 32'h1234_5678, 1'b0);
        c_req = 1'b1;
        applyStimulus(TB_TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);

        // Reset in the middle of a DMA access: no ack, everything drops
        c_req = 1'b0;
        raiseD();
        mem_ready = 1'b0;
        tick();
        checkOutput("rstmid.busy_d", 64'(busy), 64'(1'b1));
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rstmid.mem_req", 64'(mem_req), 64'(1'b0));
        checkOutput("rstmid.busy",    64'(busy),    64'(1'b0));
        checkOutput("rstmid.d_ack",   64'(d_ack),   64'(1'b0));
        reset    = 1'b0;
        d_req    = 1'b0;
        lastWasD = 1'b1;
        tick();
        checkOutput("rstpost.d_ack", 64'(d_ack), 64'(1'b0));
        checkOutput("rstpost.busy",  64'(busy),  64'(1'b0));

        // Contended grants straight after reset: C first in both builds, then
        // C,C (fixed priority) or D,C (round robin)
        for (int i = 0; i < 3; i++) begin
            if (!c_req) raiseC();
            if (!d_req) raiseD();
            applyStimulus(0, $urandom, 1'b0);
            checkOutput("contend.winner", 64'(lastWinnerD),
                        64'(RR_MODE ? (i % 2) : 0));
        end

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!c_req && $urandom_range(0, 1) == 1) raiseC();
            if (!d_req && $urandom_range(0, 1) == 1) raiseD();
            if (!c_req && !d_req) begin
                if ($urandom_range(0, 1) == 1) raiseC();
                else                           raiseD();
            end
            applyStimulus(int'($urandom_range(0, 10)), $urandom,
                          $urandom_range(0, 1) == 1);
        end

        c_req = 1'b0;
        d_req = 1'b0;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
